fetch_btb_stage: RTL and testbench
==================================

// Module: fetch_btb_stage
// PURPOSE
//   Instruction-fetch stage with a direct-mapped branch target buffer (BTB).
//   Holds the PC, predicts the next fetch address, and drives the IF/ID
//   pipeline register that feeds the decode stage (control unit, register file).
//   Branch/jump outcomes resolved in EX update the BTB and redirect fetch on mispredict.
// PARAMETERS
//   ENTRIES   16            BTB entries; power of 2, >= 2; IDXW = log2(ENTRIES)
//   RESET_PC  32'h0000_0000 fetch address after reset; word-aligned
// PORTS
//   clk          in   1   clock, all state updates on rising edge
//   rst_n        in   1   synchronous, active-low reset
//   StallF       in   1   hold PCF
//   StallD       in   1   hold IF/ID register
//   MispredE     in   1   EX detected mispredict: redirect fetch and flush IF/ID
//   CorrectPcE   in   32  redirect address when MispredE=1
//   BrUpdE       in   1   resolved branch/JAL in EX: update BTB
//   BrPcE        in   32  PC of the resolved instruction
//   BrTargetE    in   32  its computed target
//   BrTakenE     in   1   its actual direction
//   PCF          out  32  current fetch address, drives instruction memory
//   PCD          out  32  PC of the instruction in decode
//   ValidD       out  1   decode slot holds a real instruction; 0 = bubble
//   PredTakenD   out  1   prediction made for PCD
//   PredTargetD  out  32  predicted target for PCD; 0 when PredTakenD=0
// BEHAVIOUR
//   Reset (rst_n=0 at edge, beats every other input, also mid-operation):
//     PCF=RESET_PC; PCD=0, ValidD=0, PredTakenD=0, PredTargetD=0; all BTB valid bits=0.
//   BTB entry: valid, tag=PC[31:IDXW+2], target[31:2], 2-bit counter ctr.
//     Index = PC[IDXW+1:2]. Stored/issued targets and CorrectPcE use bits [1:0] forced to 2'b00.
//   Lookup (combinational on PCF): hit = valid & tag match; predTaken = hit & ctr[1].
//   Next PCF, priority high->low:
//     1 MispredE            -> {CorrectPcE[31:2],2'b00}  (overrides StallF)
//     2 StallF              -> hold
//     3 predTaken           -> entry target
//     4 otherwise           -> PCF+4, wraps 32'hFFFF_FFFC -> 0
//   IF/ID register, priority high->low:
//     1 MispredE            -> ValidD=0, PCD=0, PredTakenD=0, PredTargetD=0 (flush)
//     2 StallD              -> hold all
//     3 else                -> PCD=PCF, ValidD=1, PredTakenD=predTaken,
//                              PredTargetD = predTaken ? target : 0
//     StallF=1 with StallD=0 is a hazard-unit error; block still follows the table.
//   Decode sees a fetched PC one cycle after fetch: latency PCF -> PCD = 1 cycle.
//   BTB update on BrUpdE, written at the clock edge (index/tag taken from BrPcE):
//     hit & taken    : ctr=sat_inc(ctr) (max 2'b11), target=BrTargetE
//     hit & !taken   : ctr=sat_dec(ctr) (min 2'b00), target kept
//     miss & taken   : allocate/replace: valid=1, tag, target=BrTargetE, ctr=2'b10
//     miss & !taken  : no change
//   Update and lookup on the same index in one cycle: lookup uses pre-update contents.
//   BrUpdE is independent of MispredE and StallF; updates happen even while stalled.
// TESTING
//   T1 rst_n=0 for 2 cycles, release, no stalls -> PCF 0,4,8,C; ValidD=0 then 1 from cycle 2; PCD trails PCF by 1.
//   T2 BrUpdE: BrPcE=0x10, BrTargetE=0x40, taken -> next fetch of 0x10 gives PCF 0x40;
//      at decode PCD=0x10, PredTakenD=1, PredTargetD=0x40.
//   T3 After T2 (ctr=10): two not-taken updates at 0x10 -> ctr 01 then 00; fetch 0x10 -> next PCF 0x14, PredTakenD=0.
//   T4 MispredE=1, CorrectPcE=0x83, StallF=1, StallD=1 same cycle -> PCF=0x80 next cycle, ValidD=0, PCD=0.
//   T5 ENTRIES=16: taken entry at 0x10; fetch 0x50 (same index, other tag) -> miss, PCF 0x54;
//      taken update at 0x50 -> target 0x90 replaces entry; 0x10 now misses.
//   T6 StallF=StallD=1 for 3 cycles with BrUpdE at PCF's index -> PCF, PCD, ValidD held;
//      new prediction visible on the first cycle after the stall.

Source files
------------

// File: rtl/fetch_btb_stage.sv
// rtl/fetch_btb_stage.sv - instruction fetch stage with direct-mapped branch target buffer
module fetch_btb_stage #(
    parameter int          ENTRIES  = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        MispredE,
    input  logic [31:0] CorrectPcE,
    input  logic        BrUpdE,
    input  logic [31:0] BrPcE,
    input  logic [31:0] BrTargetE,
    input  logic        BrTakenE,
    output logic [31:0] PCF,
    output logic [31:0] PCD,
    output logic        ValidD,
    output logic        PredTakenD,
    output logic [31:0] PredTargetD
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    // BTB storage: only the valid bits need a reset, payload is qualified by them
    logic [ENTRIES-1:0] btb_valid;
    logic [TAGW-1:0]    btb_tag    [ENTRIES];
    logic [29:0]        btb_target [ENTRIES];
    logic [1:0]         btb_ctr    [ENTRIES];

    // Lookup side, indexed by the current fetch address
    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic            pred_taken;
    logic [31:0]     pred_target;

    // Update side, indexed by the resolved branch PC from EX
    logic [IDXW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;
    logic [1:0]      up_ctr;
    logic [1:0]      ctr_inc;
    logic [1:0]      ctr_dec;

    // Byte-offset bits of these addresses are always forced to zero
    logic unused_low_bits;
    assign unused_low_bits = ^{CorrectPcE[1:0], BrTargetE[1:0], BrPcE[1:0]};

    // Combinational BTB read on PCF; sees contents before any same-cycle update
    always_comb begin
        lk_idx      = PCF[IDXW+1:2];
        lk_tag      = PCF[31:IDXW+2];
        lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
        pred_taken  = lk_hit && btb_ctr[lk_idx][1];
        pred_target = {btb_target[lk_idx], 2'b00};
    end

    // Decode the update address and precompute saturating counter steps
    always_comb begin
        up_idx  = BrPcE[IDXW+1:2];
        up_tag  = BrPcE[31:IDXW+2];
        up_hit  = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
        up_ctr  = btb_ctr[up_idx];
        ctr_inc = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'b01;
        ctr_dec = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'b01;
    end

    // Next fetch address: redirect beats stall, stall beats prediction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PCF <= RESET_PC;
        end else if (MispredE) begin
            PCF <= {CorrectPcE[31:2], 2'b00};
        end else if (!StallF) begin
            PCF <= pred_taken ? pred_target : PCF + 32'd4;
        end
    end

    // IF/ID pipeline register: flush on redirect, hold on decode stall
    always_ff @(posedge clk) begin
        if (!rst_n || MispredE) begin
            PCD         <= 32'd0;
            ValidD      <= 1'b0;
            PredTakenD  <= 1'b0;
            PredTargetD <= 32'd0;
        end else if (!StallD) begin
            PCD         <= PCF;
            ValidD      <= 1'b1;
            PredTakenD  <= pred_taken;
            PredTargetD <= pred_taken ? pred_target : 32'd0;
        end
    end

    // Valid bits: cleared by reset, set when a taken branch allocates an entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btb_valid <= '0;
        end else if (BrUpdE && !up_hit && BrTakenE) begin
            btb_valid[up_idx] <= 1'b1;
        end
    end

    // BTB payload: train counter on hits, allocate on taken misses, ignore not-taken misses
    always_ff @(posedge clk) begin
        if (rst_n && BrUpdE) begin
            if (up_hit) begin
                if (BrTakenE) begin
                    btb_ctr[up_idx]    <= ctr_inc;
                    btb_target[up_idx] <= BrTargetE[31:2];
                end else begin
                    btb_ctr[up_idx]    <= ctr_dec;
                end
            end else if (BrTakenE) begin
                btb_tag[up_idx]    <= up_tag;
                btb_target[up_idx] <= BrTargetE[31:2];
                btb_ctr[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fetch_btb_stage.sv
// tb/tb_fetch_btb_stage.sv - scoreboard bench for fetch_btb_stage
module tb_fetch_btb_stage;

    logic        clk;
    logic        rst_n;
    logic        StallF;
    logic        StallD;
    logic        MispredE;
    logic [31:0] CorrectPcE;
    logic        BrUpdE;
    logic [31:0] BrPcE;
    logic [31:0] BrTargetE;
    logic        BrTakenE;
    logic [31:0] PCF;
    logic [31:0] PCD;
    logic        ValidD;
    logic        PredTakenD;
    logic [31:0] PredTargetD;

    typedef struct {
        int          cyc;
        logic [31:0] pcf;
        logic [31:0] pcd;
        logic        v;
        logic        pt;
        logic [31:0] ptg;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;

    fetch_btb_stage #(.ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .StallF      (StallF),
        .StallD      (StallD),
        .MispredE    (MispredE),
        .CorrectPcE  (CorrectPcE),
        .BrUpdE      (BrUpdE),
        .BrPcE       (BrPcE),
        .BrTargetE   (BrTargetE),
        .BrTakenE    (BrTakenE),
        .PCF         (PCF),
        .PCD         (PCD),
        .ValidD      (ValidD),
        .PredTakenD  (PredTakenD),
        .PredTargetD (PredTargetD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge
    task automatic cyc(input bit r, input bit sf, input bit sd, input bit mp, input logic [31:0] cpc,
                       input bit up, input logic [31:0] bpc, input logic [31:0] btg, input bit bt,
                       input logic [31:0] e_pcf, input logic [31:0] e_pcd, input bit e_v,
                       input bit e_pt, input logic [31:0] e_ptg);
        exp_t e;
        @(negedge clk);
        #1;
        rst_n      = r;
        StallF     = sf;
        StallD     = sd;
        MispredE   = mp;
        CorrectPcE = cpc;
        BrUpdE     = up;
        BrPcE      = bpc;
        BrTargetE  = btg;
        BrTakenE   = bt;
        e.cyc = cyc_no;
        e.pcf = e_pcf;
        e.pcd = e_pcd;
        e.v   = e_v;
        e.pt  = e_pt;
        e.ptg = e_ptg;
        exp_q.push_back(e);
        cyc_no++;
    endtask

    // Monitor: each falling edge the DUT presents the state of the previous edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pcf",         e.cyc, PCF,                 e.pcf);
                chk("pcd",         e.cyc, PCD,                 e.pcd);
                chk("valid_d",     e.cyc, {31'd0, ValidD},     {31'd0, e.v});
                chk("pred_taken",  e.cyc, {31'd0, PredTakenD}, {31'd0, e.pt});
                chk("pred_target", e.cyc, PredTargetD,         e.ptg);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout pending=%0d required=0", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; MispredE = 1'b0; CorrectPcE = '0;
        BrUpdE = 1'b0; BrPcE = '0; BrTargetE = '0; BrTakenE = 1'b0;
        //   r sf sd mp cpc              up bpc     btg      bt  pcf            pcd            v pt ptg
        // reset and sequential fetch
        cyc(0, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h0,         32'h0,         0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h0,         32'h0,         0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h4,         32'h0,         1, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h8,         32'h4,         1, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'hC,         32'h8,         1, 0, 32'h0);
        // allocate 0x10 -> 0x40 and predict it
        cyc(1, 0, 0, 0, 32'h0,          1, 32'h10, 32'h40,  1,  32'h10,        32'hC,         1, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h40,        32'h10,        1, 1, 32'h40);
        // two not-taken updates drop the counter to 00
        cyc(1, 0, 0, 0, 32'h0,          1, 32'h10, 32'h0,   0,  32'h44,        32'h40,        1, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          1, 32'h10, 32'h0,   0,  32'h48,        32'h44,        1, 0, 32'h0);
        cyc(1, 0, 0, 1, 32'h10,         0, 32'h0,  32'h0,   0,  32'h10,        32'h0,         0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h14,        32'h10,        1, 0, 32'h0);
        // mispredict overrides both stalls, low bits of redirect forced to zero
        cyc(1, 1, 1, 1, 32'h83,         0, 32'h0,  32'h0,   0,  32'h80,        32'h0,         0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h84,        32'h80,        1, 0, 32'h0);
        // train 0x10 up to saturation, then one not-taken keeps it predicting
        cyc(1, 0, 0, 0, 32'h0,          1, 32'h10, 32'h40,  1,  32'h88,        32'h84,        1, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          1, 32'h10, 32'h40,  1,  32'h8C,        32'h88,        1, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          1, 32'h10, 32'h40,  1,  32'h90,        32'h8C,        1, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          1, 32'h10, 32'h40,  1,  32'h94,        32'h90,        1, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          1, 32'h10, 32'h0,   0,  32'h98,        32'h94,        1, 0, 32'h0);
        cyc(1, 0, 0, 1, 32'h10,         0, 32'h0,  32'h0,   0,  32'h10,        32'h0,         0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h40,        32'h10,        1, 1, 32'h40);
        // aliasing 0x50 misses, then replaces the entry
        cyc(1, 0, 0, 1, 32'h50,         0, 32'h0,  32'h0,   0,  32'h50,        32'h0,         0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          1, 32'h50, 32'h90,  1,  32'h54,        32'h50,        1, 0, 32'h0);
        cyc(1, 0, 0, 1, 32'h50,         0, 32'h0,  32'h0,   0,  32'h50,        32'h0,         0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h90,        32'h50,        1, 1, 32'h90);
        cyc(1, 0, 0, 1, 32'h10,         0, 32'h0,  32'h0,   0,  32'h10,        32'h0,         0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h14,        32'h10,        1, 0, 32'h0);
        // full stall with update at PCF's index; prediction appears after the stall
        cyc(1, 1, 1, 0, 32'h0,          1, 32'h14, 32'h200, 1,  32'h14,        32'h10,        1, 0, 32'h0);
        cyc(1, 1, 1, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h14,        32'h10,        1, 0, 32'h0);
        cyc(1, 1, 1, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h14,        32'h10,        1, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h200,       32'h14,        1, 1, 32'h200);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h204,       32'h200,       1, 0, 32'h0);
        // wrap from the top of the address space
        cyc(1, 0, 0, 1, 32'hFFFF_FFFF,  0, 32'h0,  32'h0,   0,  32'hFFFF_FFFC, 32'h0,         0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h0,         32'hFFFF_FFFC, 1, 0, 32'h0);
        // split stalls
        cyc(1, 1, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h0,         32'h0,         1, 0, 32'h0);
        cyc(1, 0, 1, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h4,         32'h0,         1, 0, 32'h0);
        // mid-run reset beats everything and clears the BTB
        cyc(0, 1, 1, 1, 32'h100,        1, 32'h14, 32'h300, 1,  32'h0,         32'h0,         0, 0, 32'h0);
        cyc(1, 0, 0, 1, 32'h14,         0, 32'h0,  32'h0,   0,  32'h14,        32'h0,         0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,          0, 32'h0,  32'h0,   0,  32'h18,        32'h14,        1, 0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
